// File: rtl/gem_pad_lookup_sched.sv
// gem_pad_lookup_sched
// Schedules the per-BX GEM cluster pad -> eighth-strip lookups onto the
// dual-port pad-to-es ROM (synchronous read ports, registered read data).
// Captures up to MXCLST pads on start, drops invalid/out-of-range pads,
// issues two lookups per clock and collects results into a per-cluster bank.
//
// Handshake: start is a one-cycle strobe accepted only in IDLE. busy is high
// from the cycle after an accepted start through the done cycle. done pulses
// once per accepted start. A start seen while busy is dropped and recorded in
// the sticky start_ovf flag.
//
// Ports:
//   clock, global_reset      system clock, synchronous active-high reset
//   start, pad_in, pad_vld   capture strobe, packed pads, per-slot valid
//   rom_adr0/1, rom_rd0/1    ROM port addresses and read data
//   es_out, es_vld, pad_err  result bank, per-slot result valid, range error
//   busy, done, start_ovf    sequence status
module gem_pad_lookup_sched #(
  parameter int MXCLST    = 8,
  parameter int MXADRB    = 8,
  parameter int MXDATB    = 10,
  parameter int ROMLENGTH = 192,
  parameter int ROM_LAT   = 1
) (
  input  logic                     clock,
  input  logic                     global_reset,
  input  logic                     start,
  input  logic [MXCLST*MXADRB-1:0] pad_in,
  input  logic [MXCLST-1:0]        pad_vld,
  output logic [MXADRB-1:0]        rom_adr0,
  output logic [MXADRB-1:0]        rom_adr1,
  input  logic [MXDATB-1:0]        rom_rd0,
  input  logic [MXDATB-1:0]        rom_rd1,
  output logic [MXCLST*MXDATB-1:0] es_out,
  output logic [MXCLST-1:0]        es_vld,
  output logic [MXCLST-1:0]        pad_err,
  output logic                     busy,
  output logic                     done,
  output logic                     start_ovf
);

  localparam int SLW  = (MXCLST > 1) ? $clog2(MXCLST) : 1;
  localparam int TAGW = SLW + 1;  // {valid, slot}
  localparam int PD   = (ROM_LAT > 0) ? ROM_LAT : 1;
  localparam logic [MXADRB:0] ROMLEN_W = (MXADRB+1)'(ROMLENGTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                     state, state_nxt;
  logic [MXCLST*MXADRB-1:0]   pad_q;
  logic [MXCLST-1:0]          pending, pending_nxt, clr_mask;
  logic [MXCLST-1:0]          start_pend, start_err;
  logic [SLW-1:0]             sel0, sel1;
  logic                       sel0_vld, sel1_vld;
  logic                       issue, inflight;
  logic [TAGW-1:0]            tag0_in, tag1_in, exit0, exit1;
  logic [TAGW-1:0]            pipe0 [0:PD-1];
  logic [TAGW-1:0]            pipe1 [0:PD-1];

  assign issue = (state == ISSUE);
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

  // Range check of incoming pads at full address width (unsigned).
  always_comb begin
    start_pend = '0;
    start_err  = '0;
    for (int i = 0; i < MXCLST; i++) begin
      if (pad_vld[i]) begin
        if ({1'b0, pad_in[i*MXADRB +: MXADRB]} < ROMLEN_W) start_pend[i] = 1'b1;
        else                                               start_err[i]  = 1'b1;
      end
    end
  end

  // Lowest pending slot goes to port 0, next-lowest to port 1. Scanning
  // downward lets the last hit (lowest index) win.
  always_comb begin
    sel0     = '0;
    sel0_vld = 1'b0;
    sel1     = '0;
    sel1_vld = 1'b0;
    for (int i = MXCLST-1; i >= 0; i--) begin
      if (pending[i]) begin
        sel0     = SLW'(i);
        sel0_vld = 1'b1;
      end
    end
    for (int i = MXCLST-1; i >= 0; i--) begin
      if (pending[i] && (SLW'(i) != sel0)) begin
        sel1     = SLW'(i);
        sel1_vld = 1'b1;
      end
    end
  end

  always_comb begin
    clr_mask = '0;
    if (issue && sel0_vld) clr_mask[sel0] = 1'b1;
    if (issue && sel1_vld) clr_mask[sel1] = 1'b1;
    pending_nxt = pending & ~clr_mask;
  end

  assign rom_adr0 = (issue && sel0_vld) ? pad_q[int'(sel0)*MXADRB +: MXADRB] : '0;
  assign rom_adr1 = (issue && sel1_vld) ? pad_q[int'(sel1)*MXADRB +: MXADRB] : '0;
  assign tag0_in  = {issue && sel0_vld, sel0};
  assign tag1_in  = {issue && sel1_vld, sel1};

  // Tag pipeline: the tag leaves the pipeline in the same cycle the ROM
  // presents data for the address issued alongside it.
  generate
    if (ROM_LAT == 0) begin : g_lat0
      assign exit0 = tag0_in;
      assign exit1 = tag1_in;
    end else begin : g_latn
      assign exit0 = pipe0[ROM_LAT-1];
      assign exit1 = pipe1[ROM_LAT-1];
    end
  endgenerate

  // Port 0 is always used whenever anything issues, so its valid bits alone
  // tell whether lookups are still in flight behind the exiting stage.
  always_comb begin
    inflight = 1'b0;
    for (int i = 0; i < ROM_LAT-1; i++) inflight = inflight | pipe0[i][TAGW-1];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (start_pend != '0) ? ISSUE : DONE;
      ISSUE: if (pending_nxt == '0) state_nxt = (ROM_LAT > 0) ? DRAIN : DONE;
      DRAIN: if (!inflight) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (global_reset) begin
      state     <= IDLE;
      pad_q     <= '0;
      pending   <= '0;
      pad_err   <= '0;
      es_out    <= '0;
      es_vld    <= '0;
      start_ovf <= 1'b0;
      for (int i = 0; i < PD; i++) begin
        pipe0[i] <= '0;
        pipe1[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (start && (state != IDLE)) start_ovf <= 1'b1;

      pipe0[0] <= tag0_in;
      pipe1[0] <= tag1_in;
      for (int i = 1; i < PD; i++) begin
        pipe0[i] <= pipe0[i-1];
        pipe1[i] <= pipe1[i-1];
      end

      if ((state == IDLE) && start) begin
        pad_q   <= pad_in;
        pending <= start_pend;
        pad_err <= start_err;
        es_out  <= '0;
        es_vld  <= '0;
      end else if (issue) begin
        pending <= pending_nxt;
      end

      if (exit0[TAGW-1]) begin
        es_out[int'(exit0[SLW-1:0])*MXDATB +: MXDATB] <= rom_rd0;
        es_vld[exit0[SLW-1:0]] <= 1'b1;
      end
      if (exit1[TAGW-1]) begin
        es_out[int'(exit1[SLW-1:0])*MXDATB +: MXDATB] <= rom_rd1;
        es_vld[exit1[SLW-1:0]] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gem_pad_lookup_sched.sv
// Testbench for gem_pad_lookup_sched: ROM model returns pad*4 with one cycle
// of registered latency. Vector table plus hand-written overlap/reset cases.
module tb_gem_pad_lookup_sched;

  logic        clock = 1'b0;
  logic        global_reset;
  logic        start;
  logic [63:0] pad_in;
  logic [7:0]  pad_vld;
  logic [7:0]  rom_adr0, rom_adr1;
  logic [9:0]  rom_rd0, rom_rd1;
  logic [79:0] es_out;
  logic [7:0]  es_vld, pad_err;
  logic        busy, done, start_ovf;

  always #5 clock = ~clock;

  gem_pad_lookup_sched dut (
    .clock(clock), .global_reset(global_reset), .start(start),
    .pad_in(pad_in), .pad_vld(pad_vld),
    .rom_adr0(rom_adr0), .rom_adr1(rom_adr1),
    .rom_rd0(rom_rd0), .rom_rd1(rom_rd1),
    .es_out(es_out), .es_vld(es_vld), .pad_err(pad_err),
    .busy(busy), .done(done), .start_ovf(start_ovf)
  );

  // ROM model: registered read data, content = pad*4.
  always @(posedge clock) begin
    rom_rd0 <= {rom_adr0, 2'b00};
    rom_rd1 <= {rom_adr1, 2'b00};
  end

  typedef struct {
    logic [63:0] pads;
    logic [7:0]  vld;
    logic [79:0] exp_es;
    logic [7:0]  exp_vld;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t        vecs [0:6];
  logic [15:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        exp_ovf  = 1'b0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model of the result bank for one start.
  function automatic vec_t make_vec(input logic [63:0] pads, input logic [7:0] vld);
    vec_t v;
    logic [7:0] p;
    v.pads = pads; v.vld = vld;
    v.exp_es = '0; v.exp_vld = '0; v.exp_err = '0;
    for (int i = 0; i < 8; i++) begin
      p = pads[i*8 +: 8];
      if (vld[i] && (p < 8'd192)) begin
        v.exp_vld[i] = 1'b1;
        v.exp_es[i*10 +: 10] = {p, 2'b00};
      end else if (vld[i]) begin
        v.exp_err[i] = 1'b1;
      end
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Apply one vector; optional second start in cycle ovf_at after T (0 = none).
  task automatic run_case(input vec_t v, input int ovf_at);
    logic [7:0]  list [$];
    logic [7:0]  a1;
    logic [15:0] pair;
    int k, n, done_c;
    for (int i = 0; i < 8; i++)
      if (v.exp_vld[i]) list.push_back(v.pads[i*8 +: 8]);
    k = list.size();
    for (int j = 0; j < k; j += 2) begin
      a1 = (j + 1 < k) ? list[j+1] : 8'd0;
      exp_q.push_back({list[j], a1});
    end
    n = (k + 1) / 2;
    done_c = (k > 0) ? n + 2 : 1;

    pad_in = v.pads; pad_vld = v.vld; start = 1'b1;
    tick();
    for (int c = 1; c <= done_c + 1; c++) begin
      if (c == ovf_at) begin
        start = 1'b1; pad_in = ~v.pads; pad_vld = 8'hFF; exp_ovf = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      if (c <= n) begin
        pair = exp_q.pop_front();
        check("rom_adr", {rom_adr0, rom_adr1}, pair);
      end else begin
        check("rom_adr_idle", {rom_adr0, rom_adr1}, 16'h0);
      end
      check("done", done, c == done_c);
      check("busy", busy, c <= done_c);
      tick();
    end
    start = 1'b0;
    check("es_out", es_out, v.exp_es);
    check("es_vld", es_vld, v.exp_vld);
    check("pad_err", pad_err, v.exp_err);
    check("start_ovf", start_ovf, exp_ovf);
    check("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [63:0] p;

    // Vector table.
    p = '0;
    for (int i = 0; i < 8; i++) p[i*8 +: 8] = 8'(i);
    vecs[0] = make_vec(p, 8'hFF);
    p = '0; p[0 +: 8] = 8'd191; p[16 +: 8] = 8'd192; p[40 +: 8] = 8'd10;
    vecs[1] = make_vec(p, 8'b0010_0101);
    vecs[2] = make_vec({$urandom, $urandom}, 8'h00);
    p = '0; p[8 +: 8] = 8'd50; p[24 +: 8] = 8'd50; p[48 +: 8] = 8'd50; p[56 +: 8] = 8'd255;
    vecs[3] = make_vec(p, 8'b1100_1010);
    for (int i = 4; i < 7; i++)
      vecs[i] = make_vec({$urandom, $urandom}, 8'($urandom_range(0, 255)));

    // Clock/reset.
    global_reset = 1'b1; start = 1'b0; pad_in = '0; pad_vld = '0;
    repeat (3) tick();
    global_reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("rst_adr", {rom_adr0, rom_adr1}, 16'h0);
      check("rst_out", {es_out, es_vld, pad_err}, 96'h0);
      check("rst_flags", {busy, done, start_ovf}, 3'b000);
      tick();
    end

    for (int i = 0; i < 7; i++) begin
      run_case(vecs[i], 0);
      repeat ($urandom_range(0, 2)) tick();
    end

    // Start in the done cycle is ignored (sets start_ovf, no restart).
    run_case(vecs[1], 3);
    // Start two cycles into an 8-slot sequence is ignored.
    run_case(vecs[0], 2);
    tick();
    check("ovf_sticky", start_ovf, 1'b1);

    // Reset at T+2 of an 8-slot sequence aborts it.
    pad_in = vecs[0].pads; pad_vld = vecs[0].vld; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    global_reset = 1'b1;
    tick();
    global_reset = 1'b0;
    exp_ovf = 1'b0;
    @(negedge clock);
    check("abort_out", {es_out, es_vld, pad_err}, 96'h0);
    check("abort_flags", {busy, done, start_ovf}, 3'b000);
    check("abort_adr", {rom_adr0, rom_adr1}, 16'h0);
    for (int c = 0; c < 6; c++) begin
      tick();
      @(negedge clock);
      check("abort_no_done", done, 1'b0);
    end
    tick();
    run_case(vecs[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gem_pad_lookup_sched.md
Name: gem_pad_lookup_sched

Overview:
- Sequences per-BX GEM cluster pad-to-eighth-strip lookups onto the dual-port pad-to-es ROM (two synchronous read ports, registered read data).
- Captures up to MXCLST cluster pads on a start strobe and skips invalid or out-of-range pads.
- Issues two lookups per clock, one per ROM port, and tracks ROM latency with a tag pipeline.
- Collects results into a per-cluster result bank and pulses done; sits between the GEM cluster receiver and the GEM-CSC matching logic.

Parameters:
- MXCLST, 8, cluster slots captured per start
- MXADRB, 8, pad address width (ROM address width)
- MXDATB, 10, ROM data width (eighth-strip)
- ROMLENGTH, 192, valid pad range 0..ROMLENGTH-1
- ROM_LAT, 1, cycles from address-presented cycle to ROM data-valid cycle

Ports:
- clock  in  1  single system clock
- global_reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle strobe: capture pad_in/pad_vld
- pad_in  in  MXCLST*MXADRB  packed pads, slot i at [i*MXADRB +: MXADRB]
- pad_vld  in  MXCLST  per-slot valid
- rom_adr0  out  MXADRB  ROM port 0 address
- rom_adr1  out  MXADRB  ROM port 1 address
- rom_rd0  in  MXDATB  ROM port 0 read data
- rom_rd1  in  MXDATB  ROM port 1 read data
- es_out  out  MXCLST*MXDATB  result bank, slot i at [i*MXDATB +: MXDATB]
- es_vld  out  MXCLST  slot has a valid lookup result
- pad_err  out  MXCLST  slot was valid but pad >= ROMLENGTH
- busy  out  1  high from the cycle after an accepted start through the done cycle
- done  out  1  one-cycle pulse: results complete
- start_ovf  out  1  sticky: start received while busy; cleared only by reset

Behaviour:
- Reset (synchronous, global_reset=1 at a clock edge):
  - State goes to IDLE.
  - es_out, es_vld, pad_err, rom_adr0, rom_adr1, busy, done, start_ovf all go to 0.
  - The pending mask and the tag pipeline clear.
  - Reset mid-operation aborts the sequence; no done is produced.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 latches pads.
  - pending = pad_vld & (pad < ROMLENGTH).
  - pad_err = pad_vld & (pad >= ROMLENGTH).
  - es_vld and es_out clear to 0 in the same edge.
  - Next state is ISSUE if pending != 0, else DONE.
- ISSUE, each cycle:
  - Select the lowest-index pending slot for port 0 and the next-lowest for port 1.
  - Drive rom_adr0 and rom_adr1 combinationally from the latched pads.
  - Push tags {valid, slot index} for both ports into a ROM_LAT-deep shift pipeline.
  - Clear the selected bits from pending.
  - An unused port carries tag valid=0 and address 0.
  - Leave ISSUE when pending becomes 0 this cycle: go to DRAIN if ROM_LAT > 0, else DONE.
  - ceil(k/2) issue cycles for k pending slots.
- Capture:
  - When a tag exits the pipeline with valid=1, latch rom_rdN into es_out[slot] and set es_vld[slot].
  - Ports 0 and 1 capture independently in the same cycle.
- DRAIN: wait ROM_LAT cycles until the pipeline is empty, then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE; busy drops with done.
- Results persist: es_out, es_vld and pad_err hold until the next accepted start or reset.
- start while busy (ISSUE/DRAIN/DONE):
  - Ignored; in-flight lookup unaffected.
  - start_ovf is set.
- start in the same cycle as done is also ignored (state is DONE, not IDLE).
- Duplicate pads in different slots are looked up independently and both slots get results.
- es_out for non-valid or error slots is 0.
- Latency for an accepted start at cycle T with k > 0 lookups:
  - Issue cycles are T+1 .. T+ceil(k/2).
  - done is asserted at T+ceil(k/2)+ROM_LAT+1.
  - With k = 0: done at T+1.
- No arithmetic beyond comparison; pad compared unsigned against ROMLENGTH at full MXADRB width.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, rom_adr0/1 = 0, busy=0.
- start at T, all 8 slots valid, pads 0,1,...,7; ROM model returns pad*4 -> adr pairs (0,1),(2,3),(4,5),(6,7) on T+1..T+4; done at T+6; es_out[i]=4*i; es_vld=8'hFF; pad_err=0.
- start with pad_vld=8'b0010_0101, pads slot0=191, slot2=192, slot5=10 -> pad_err=8'b0000_0100; one issue cycle with adr0=191, adr1=10; done at T+3; es_vld=8'b0010_0001; es_out[2]=0.
- start with pad_vld=0 -> no ROM addresses driven, done at T+1, es_vld=0.
- start, then second start at T+2 -> second start ignored, start_ovf=1 and held; first result set correct; done only once.
- global_reset at T+2 of an 8-slot sequence -> no done, all outputs 0 next cycle; a fresh start then completes normally.
